// File: rtl/cla_arb_pkg.sv
// Shared types and helpers for the cla_arbiter slice: FSM state encoding and
// the round-robin pointer advance.
package cla_arb_pkg;

    typedef enum logic {EMPTY, FULL} cla_arb_state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cla.sv
// Carry-lookahead adder built from 4-bit lookahead blocks; the block
// generate/propagate terms chain the carry between blocks.
module cla #(
    parameter int width = 32
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);
    localparam int NB = width / 4;

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width-1:0] c;
    logic             c_out;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic carry;
        logic blk_g;
        logic blk_p;
        c     = '0;
        carry = cin;
        for (int k = 0; k < NB; k++) begin
            c[4*k]   = carry;
            c[4*k+1] = g[4*k]   | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            blk_g    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            blk_p    = &p[4*k +: 4];
            carry    = blk_g | (blk_p & carry);
        end
        c_out = carry;
    end

    assign sum  = p ^ c;
    assign cout = c_out;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr
// wins; en gates the one-hot grant but not the binary winner index.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        logic found;
        int   idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        if (found && en) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/cla_arbiter.sv
// Round-robin sequencer sharing one cla adder among NREQ requesters, with a
// single-entry result register. Define CLA_ARB_OVF_EN to add rsp_ovf.
module cla_arbiter
    import cla_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
`ifdef CLA_ARB_OVF_EN
    output logic                  rsp_ovf,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_arbiter: WIDTH must be a positive multiple of 4");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("cla_arbiter: NREQ must be in 2..16");
    end

    cla_arb_state_t   state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [IDW-1:0]   id_q;

    logic             can_accept;
    logic             xfer;
    logic [IDW-1:0]   gnt_id;
    logic [WIDTH-1:0] a_sel, b_sel, add_sum;
    logic             cin_sel, add_cout;

    assign rsp_valid  = (state_q == FULL);
    assign can_accept = (state_q == EMPTY) | (rsp_ready & rsp_valid);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (can_accept),
        .gnt    (req_ready),
        .gnt_id (gnt_id)
    );

    assign xfer    = |(req_valid & req_ready);
    assign a_sel   = req_a[int'(gnt_id)*WIDTH +: WIDTH];
    assign b_sel   = req_b[int'(gnt_id)*WIDTH +: WIDTH];
    assign cin_sel = req_cin[gnt_id];

    cla #(.width(WIDTH)) u_cla (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (rsp_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) ptr_d = IDW'(rr_next(int'(gnt_id), NREQ));
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (xfer) begin
                sum_q  <= add_sum;
                cout_q <= add_cout;
                id_q   <= gnt_id;
            end
        end
    end

    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_id   = id_q;

`ifdef CLA_ARB_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Signed overflow: like-signed operands producing a sum of the other sign.
    assign ovf_d = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) & (add_sum[WIDTH-1] != a_sel[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf_q <= 1'b0;
        else if (xfer) ovf_q <= ovf_d;
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_arbiter.sv
// Directed self-checking bench for cla_arbiter (NREQ=4, WIDTH=32); inputs
// change on the falling edge, outputs are sampled away from the rising edge.
module tb_cla_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [1:0]            rsp_id;
`ifdef CLA_ARB_OVF_EN
    logic                  rsp_ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cla_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef CLA_ARB_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    function automatic logic [32:0] add_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = cin;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", rsp_valid);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_req(2, 32'h0000_1000, 32'h0000_0234, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        if (req_ready !== 4'b0100) $display("FAIL rst_pre_ready: got %b want 0100", req_ready);
        else n_pass++;
        n_checks++;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_sum !== 32'h1234)
            $display("FAIL rst_pre_hold: got valid=%b sum=%h want valid=1 sum=00001234", rsp_valid, rsp_sum);
        else n_pass++;
        n_checks++;
        #2;
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rsp_valid);
        else n_pass++;
        n_checks++;
        if (rsp_sum !== '0) $display("FAIL rst_sum: got %h want 0", rsp_sum);
        else n_pass++;
        n_checks++;
        if (rsp_cout !== 1'b0 || rsp_id !== 2'd0)
            $display("FAIL rst_cout_id: got cout=%b id=%0d want 0/0", rsp_cout, rsp_id);
        else n_pass++;
        n_checks++;
`ifdef CLA_ARB_OVF_EN
        if (rsp_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", rsp_ovf);
        else n_pass++;
        n_checks++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd10, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        if (req_ready !== 4'b0001) $display("FAIL rst_first_grant: got %b want 0001", req_ready);
        else n_pass++;
        n_checks++;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd10)
            $display("FAIL rst_first_rsp: got valid=%b id=%0d sum=%h want 1/0/0000000a",
                     rsp_valid, rsp_id, rsp_sum);
        else n_pass++;
        n_checks++;
        drain();
    endtask

    task automatic test_single_add();
        @(negedge clk);
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready);
        else n_pass++;
        n_checks++;
        @(negedge clk);
        if (rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rsp_valid);
        else n_pass++;
        n_checks++;
        if (rsp_sum !== 32'd0) $display("FAIL single_sum: got %h want 0", rsp_sum);
        else n_pass++;
        n_checks++;
        if (rsp_cout !== 1'b1) $display("FAIL single_cout: got %b want 1", rsp_cout);
        else n_pass++;
        n_checks++;
        if (rsp_id !== 2'd2) $display("FAIL single_id: got %0d want 2", rsp_id);
        else n_pass++;
        n_checks++;
        drain();
    endtask

    logic [31:0] rr_a   [NREQ] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF};
    logic [31:0] rr_b   [NREQ] = '{32'h0000_0002, 32'h0000_0001, 32'h0001_0000, 32'h0000_0000};
    logic        rr_cin [NREQ] = '{1'b0, 1'b0, 1'b1, 1'b1};

    task automatic test_round_robin();
        logic [32:0] exp;
        int          w;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, rr_a[i], rr_b[i], rr_cin[i]);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = k % NREQ;
            #1;
            if (req_ready !== 4'(1 << w)) $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << w));
            else n_pass++;
            n_checks++;
            @(negedge clk);
            exp = add_ref(rr_a[w], rr_b[w], rr_cin[w]);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(w))
                $display("FAIL rr_id[%0d]: got valid=%b id=%0d want 1/%0d", k, rsp_valid, rsp_id, w);
            else n_pass++;
            n_checks++;
            if ({rsp_cout, rsp_sum} !== exp)
                $display("FAIL rr_result[%0d]: got %h want %h", k, {rsp_cout, rsp_sum}, exp);
            else n_pass++;
            n_checks++;
        end
    endtask

    // Continues from round-robin: FULL holding requester 0, pointer at 1.
    task automatic test_backpressure();
        logic [32:0] held;
        logic [32:0] exp;
        held      = add_ref(rr_a[0], rr_b[0], rr_cin[0]);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
            else n_pass++;
            n_checks++;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_cout, rsp_sum} !== held)
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d res=%h want 1/0/%h",
                         k, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, held);
            else n_pass++;
            n_checks++;
        end
        rsp_ready = 1'b1;
        for (int w = 1; w <= 2; w++) begin
            #1;
            if (req_ready !== 4'(1 << w)) $display("FAIL bp_resume_ready[%0d]: got %b want %b", w, req_ready, 4'(1 << w));
            else n_pass++;
            n_checks++;
            @(negedge clk);
            exp = add_ref(rr_a[w], rr_b[w], rr_cin[w]);
            if (rsp_id !== 2'(w) || {rsp_cout, rsp_sum} !== exp)
                $display("FAIL bp_resume_rsp[%0d]: got id=%0d res=%h want %0d/%h",
                         w, rsp_id, {rsp_cout, rsp_sum}, w, exp);
            else n_pass++;
            n_checks++;
        end
    endtask

    // Continues from backpressure: FULL holding requester 2, pointer at 3.
    task automatic test_drain_accept();
        set_req(1, 32'd5, 32'd7, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        if (req_ready !== 4'b0010) $display("FAIL da_ready: got %b want 0010", req_ready);
        else n_pass++;
        n_checks++;
        @(negedge clk);
        if (rsp_valid !== 1'b1) $display("FAIL da_valid: got %b want 1", rsp_valid);
        else n_pass++;
        n_checks++;
        if (rsp_sum !== 32'd13 || rsp_cout !== 1'b0)
            $display("FAIL da_sum: got sum=%h cout=%b want 0000000d/0", rsp_sum, rsp_cout);
        else n_pass++;
        n_checks++;
        if (rsp_id !== 2'd1) $display("FAIL da_id: got %0d want 1", rsp_id);
        else n_pass++;
        n_checks++;
        drain();
    endtask

`ifdef CLA_ARB_OVF_EN
    logic [31:0] ov_a    [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    logic [31:0] ov_b    [3] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0001};
    logic [31:0] ov_sum  [3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0002};
    logic        ov_cout [3] = '{1'b0, 1'b1, 1'b0};
    logic        ov_ovf  [3] = '{1'b1, 1'b1, 1'b0};

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req(0, ov_a[k], ov_b[k], 1'b0);
            req_valid = 4'b0001;
            rsp_ready = 1'b0;
            @(negedge clk);
            if (rsp_ovf !== ov_ovf[k] || rsp_cout !== ov_cout[k] || rsp_sum !== ov_sum[k])
                $display("FAIL ovf[%0d]: got ovf=%b cout=%b sum=%h want %b/%b/%h",
                         k, rsp_ovf, rsp_cout, rsp_sum, ov_ovf[k], ov_cout[k], ov_sum[k]);
            else n_pass++;
            n_checks++;
            drain();
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_drain_accept();
`ifdef CLA_ARB_OVF_EN
        test_overflow();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
